// File: rtl/spi_master.sv
// Command-driven SPI master: each accepted command becomes one 16-bit frame
// (7-bit address MSB first, rw bit, 8 data bits MSB first) with one response pulse.
module spi_master #(
  parameter int CLKDIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic [15:0]      shift_q, shift_d;
  logic             rd_q, rd_d;
  logic [7:0]       rx_q, rx_d;
  logic             gap_half_q, gap_half_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic             sclk_q, sclk_d;
  logic             cs_q, cs_d;
  logic             mosi_q, mosi_d;
  logic             div_last;

  assign div_last = (div_q == DIV_LAST);

  // Handshake: a command transfers on a clk edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so cmd_valid at any other time is ignored.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    rd_d        = rd_q;
    rx_d        = rx_q;
    gap_half_d  = gap_half_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    sclk_d      = sclk_q;
    cs_d        = cs_q;
    mosi_d      = mosi_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = ST_SETUP;
          div_d       = '0;
          bit_d       = 4'd0;
          shift_d     = {cmd_addr, cmd_rw, (cmd_rw ? 8'h00 : cmd_wdata)};
          rd_d        = cmd_rw;
          gap_half_d  = 1'b0;
          cmd_ready_d = 1'b0;
          cs_d        = 1'b0;
          sclk_d      = 1'b0;
          mosi_d      = cmd_addr[6];
        end
      end
      ST_SETUP: begin
        if (div_last) begin
          state_d = ST_HIGH;
          div_d   = '0;
          sclk_d  = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_HIGH: begin
        if (div_last) begin
          state_d = ST_LOW;
          div_d   = '0;
          sclk_d  = 1'b0;
          // Data bits of a read are sampled as late as possible in the high phase.
          if (rd_q && bit_q[3]) rx_d = {rx_q[6:0], miso_pin};
          if (bit_q != 4'd15) begin
            shift_d = shift_q << 1;
            mosi_d  = shift_q[14];
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_LOW: begin
        if (div_last) begin
          div_d = '0;
          if (bit_q == 4'd15) begin
            state_d     = ST_GAP;
            gap_half_d  = 1'b0;
            cs_d        = 1'b1;
            mosi_d      = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rd_q ? rx_q : 8'h00;
          end else begin
            state_d = ST_HIGH;
            bit_d   = bit_q + 4'd1;
            sclk_d  = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_GAP: begin
        // Two divider passes give the 2*CLKDIV chip-select high time.
        if (div_last) begin
          div_d = '0;
          if (gap_half_q) begin
            state_d     = ST_IDLE;
            cmd_ready_d = 1'b1;
          end else begin
            gap_half_d = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        div_d       = '0;
        cmd_ready_d = 1'b1;
        cs_d        = 1'b1;
        sclk_d      = 1'b0;
        mosi_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      bit_q       <= 4'd0;
      shift_q     <= 16'h0000;
      rd_q        <= 1'b0;
      rx_q        <= 8'h00;
      gap_half_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      sclk_q      <= 1'b0;
      cs_q        <= 1'b1;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rd_q        <= rd_d;
      rx_q        <= rx_d;
      gap_half_q  <= gap_half_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      sclk_q      <= sclk_d;
      cs_q        <= cs_d;
      mosi_q      <= mosi_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign sclk_pin  = sclk_q;
  assign cs_pin    = cs_q;
  assign mosi_pin  = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLKDIV=4 and CLKDIV=2), each talking to a
// behavioural SPI memory slave; frames and read data are checked against a reference memory.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid4 = 1'b0, cmd_valid2 = 1'b0;
  logic [6:0] cmd_addr = 7'h00;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_wdata = 8'h00;

  logic       cmd_ready4, rsp_valid4, sclk4, cs4, mosi4, miso4;
  logic       cmd_ready2, rsp_valid2, sclk2, cs2, mosi2, miso2;
  logic [7:0] rsp_rdata4, rsp_rdata2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_master #(.CLKDIV(4)) dut4 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
    .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid4), .rsp_rdata(rsp_rdata4),
    .sclk_pin(sclk4), .cs_pin(cs4), .mosi_pin(mosi4), .miso_pin(miso4)
  );

  spi_master #(.CLKDIV(2)) dut2 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
    .sclk_pin(sclk2), .cs_pin(cs2), .mosi_pin(mosi2), .miso_pin(miso2)
  );

  // Behavioural SPI memory slaves: sample MOSI on SCLK rise, drive MISO after SCLK fall.
  logic [1:0] sclk_w, cs_w, mosi_w;
  assign sclk_w = {sclk2, sclk4};
  assign cs_w   = {cs2, cs4};
  assign mosi_w = {mosi2, mosi4};

  for (genvar g = 0; g < 2; g++) begin : g_slave
    logic [7:0]  mem [128] = '{default: 8'h00};
    logic [15:0] sh = 16'h0000;
    int          bitn = 0;
    logic        rd = 1'b0;
    logic [7:0]  tx = 8'h00;
    logic        miso = 1'b0;
    always @(posedge sclk_w[g] or posedge cs_w[g]) begin
      if (cs_w[g]) bitn = 0;
      else begin
        sh = {sh[14:0], mosi_w[g]};
        bitn++;
        if (bitn == 16 && !sh[8]) mem[sh[15:9]] = sh[7:0];
      end
    end
    always @(negedge sclk_w[g]) begin
      if (!cs_w[g]) begin
        if (bitn == 8) begin rd = sh[0]; tx = mem[sh[7:1]]; end
        if (rd && bitn >= 8 && bitn < 16) begin miso = tx[7]; tx = {tx[6:0], 1'b0}; end
      end
    end
  end
  assign miso4 = g_slave[0].miso;
  assign miso2 = g_slave[1].miso;

  // Observation mux: sel=0 watches the CLKDIV=4 instance, sel=1 the CLKDIV=2 instance.
  logic       sel = 1'b0;
  logic       o_cs, o_sclk, o_mosi, o_ready, o_rv;
  logic [7:0] o_rdata;
  assign o_cs    = sel ? cs2 : cs4;
  assign o_sclk  = sel ? sclk2 : sclk4;
  assign o_mosi  = sel ? mosi2 : mosi4;
  assign o_ready = sel ? cmd_ready2 : cmd_ready4;
  assign o_rv    = sel ? rsp_valid2 : rsp_valid4;
  assign o_rdata = sel ? rsp_rdata2 : rsp_rdata4;

  // Reference memory per slave, updated only from the commands the bench issues.
  logic [7:0] exp_mem [2][128] = '{default: 8'h00};

  function automatic logic [15:0] exp_frame(input logic [6:0] a, input logic r, input logic [7:0] w);
    return {a, r, (r ? 8'h00 : w)};
  endfunction

  logic [15:0] obs_bits;
  logic [7:0]  rsp_data;
  int n_rise, first_rise_t, cs_low, rsp_cnt, rsp_t, ready_t, bad_runs, mosi_bad, gap_cnt, wait_cyc;
  bit timed_out;
  logic [6:0] nxt_addr;
  logic       nxt_rw;
  logic [7:0] nxt_wdata;

  // Issues one command (call at a negedge) and records what the bus did until cmd_ready returns.
  // keep=1 leaves cmd_valid high and swaps the inputs to nxt_* mid-frame.
  task automatic run_frame(input bit s, input logic [6:0] a, input logic r, input logic [7:0] w, input bit keep);
    int cd, t, run_len;
    logic prev_sclk, prev_mosi, prev_cs;
    cd = s ? 2 : 4;
    sel = s;
    cmd_addr = a; cmd_rw = r; cmd_wdata = w;
    cmd_valid4 = !s; cmd_valid2 = s;
    wait_cyc = 0; timed_out = 0;
    while (!o_ready && wait_cyc < 100) begin @(negedge clk); wait_cyc++; end
    obs_bits = 16'h0000; rsp_data = 8'h00;
    n_rise = 0; first_rise_t = 0; cs_low = 0; rsp_cnt = 0; rsp_t = 0; ready_t = 0;
    bad_runs = 0; mosi_bad = 0; gap_cnt = 0;
    if (!o_ready) begin
      timed_out = 1; cmd_valid4 = 0; cmd_valid2 = 0;
      return;
    end
    prev_sclk = 1'b0; prev_mosi = o_mosi; prev_cs = 1'b1; run_len = 0; t = 0;
    while (ready_t == 0 && t < 40 * cd) begin
      @(negedge clk);
      t++;
      if (t == 1 && !keep) begin cmd_valid4 = 0; cmd_valid2 = 0; end
      if (t == 2 * cd) begin
        if (keep) begin cmd_addr = nxt_addr; cmd_rw = nxt_rw; cmd_wdata = nxt_wdata; end
        else begin
          cmd_addr = 7'($urandom_range(0, 127)); cmd_rw = 1'($urandom_range(0, 1));
          cmd_wdata = 8'($urandom_range(0, 255));
        end
      end
      if (!o_cs) begin
        cs_low++;
        if (t > 1 && o_sclk != prev_sclk) begin
          if (run_len != cd) bad_runs++;
          run_len = 1;
        end else run_len++;
      end else if (!prev_cs) begin
        if (run_len != cd) bad_runs++;
      end
      if (o_cs && !o_ready) gap_cnt++;
      if (o_sclk && !prev_sclk) begin
        n_rise++;
        obs_bits = {obs_bits[14:0], o_mosi};
        if (n_rise == 1) first_rise_t = t;
      end
      if (o_sclk && o_mosi !== prev_mosi) mosi_bad++;
      if (o_rv) begin
        rsp_cnt++;
        if (rsp_t == 0) begin rsp_t = t; rsp_data = o_rdata; end
      end
      if (o_ready) ready_t = t;
      prev_sclk = o_sclk; prev_mosi = o_mosi; prev_cs = o_cs;
    end
    if (ready_t == 0) timed_out = 1;
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    #1;
    n_vec++; if (cs4 !== 1'b1) begin n_err++; $display("FAIL reset_cs4: got %b want 1", cs4); end
    n_vec++; if (sclk4 !== 1'b0) begin n_err++; $display("FAIL reset_sclk4: got %b want 0", sclk4); end
    n_vec++; if (mosi4 !== 1'b0) begin n_err++; $display("FAIL reset_mosi4: got %b want 0", mosi4); end
    n_vec++; if (cmd_ready4 !== 1'b1) begin n_err++; $display("FAIL reset_ready4: got %b want 1", cmd_ready4); end
    n_vec++; if (rsp_valid4 !== 1'b0) begin n_err++; $display("FAIL reset_rv4: got %b want 0", rsp_valid4); end
    n_vec++; if (rsp_rdata4 !== 8'h00) begin n_err++; $display("FAIL reset_rdata4: got %h want 00", rsp_rdata4); end
    n_vec++; if (cs2 !== 1'b1) begin n_err++; $display("FAIL reset_cs2: got %b want 1", cs2); end
    n_vec++; if (sclk2 !== 1'b0) begin n_err++; $display("FAIL reset_sclk2: got %b want 0", sclk2); end
    n_vec++; if (cmd_ready2 !== 1'b1) begin n_err++; $display("FAIL reset_ready2: got %b want 1", cmd_ready2); end
    n_vec++; if (rsp_rdata2 !== 8'h00) begin n_err++; $display("FAIL reset_rdata2: got %h want 00", rsp_rdata2); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (cs4 !== 1'b1 || cmd_ready4 !== 1'b1) begin n_err++; $display("FAIL idle_after_reset: got cs=%b rdy=%b want 1 1", cs4, cmd_ready4); end
  endtask

  task automatic test_write;
    @(negedge clk);
    run_frame(0, 7'h61, 1'b0, 8'hB1, 0);
    exp_mem[0][7'h61] = 8'hB1;
    n_vec++; if (timed_out) begin n_err++; $display("FAIL wr_timeout: got timeout want completion"); end
    n_vec++; if (obs_bits !== 16'b1100001_0_10110001) begin n_err++; $display("FAIL wr_mosi: got %b want 1100001010110001", obs_bits); end
    n_vec++; if (n_rise != 16) begin n_err++; $display("FAIL wr_rises: got %0d want 16", n_rise); end
    n_vec++; if (first_rise_t != 5) begin n_err++; $display("FAIL wr_first_rise: got %0d want 5", first_rise_t); end
    n_vec++; if (cs_low != 132) begin n_err++; $display("FAIL wr_cs_low: got %0d want 132", cs_low); end
    n_vec++; if (rsp_cnt != 1) begin n_err++; $display("FAIL wr_rsp_cnt: got %0d want 1", rsp_cnt); end
    n_vec++; if (rsp_t != 133) begin n_err++; $display("FAIL wr_rsp_time: got %0d want 133", rsp_t); end
    n_vec++; if (rsp_data !== 8'h00) begin n_err++; $display("FAIL wr_rdata: got %h want 00", rsp_data); end
    n_vec++; if (ready_t != 141) begin n_err++; $display("FAIL wr_ready_time: got %0d want 141", ready_t); end
    n_vec++; if (bad_runs != 0) begin n_err++; $display("FAIL wr_half_period: got %0d bad want 0", bad_runs); end
    n_vec++; if (mosi_bad != 0) begin n_err++; $display("FAIL wr_mosi_stable: got %0d changes while high want 0", mosi_bad); end
  endtask

  task automatic test_read;
    @(negedge clk);
    run_frame(0, 7'h61, 1'b1, 8'h3C, 0);
    n_vec++; if (obs_bits !== 16'b1100001_1_00000000) begin n_err++; $display("FAIL rd_mosi: got %b want 1100001100000000", obs_bits); end
    n_vec++; if (rsp_data !== 8'hB1) begin n_err++; $display("FAIL rd_rdata: got %h want b1", rsp_data); end
    n_vec++; if (rsp_cnt != 1) begin n_err++; $display("FAIL rd_rsp_cnt: got %0d want 1", rsp_cnt); end
    repeat (3) @(negedge clk);
    n_vec++; if (rsp_rdata4 !== 8'hB1) begin n_err++; $display("FAIL rd_rdata_held: got %h want b1", rsp_rdata4); end
  endtask

  task automatic test_memory;
    @(negedge clk);
    run_frame(0, 7'h7E, 1'b0, 8'hCE, 0);
    exp_mem[0][7'h7E] = 8'hCE;
    @(negedge clk);
    run_frame(0, 7'h7E, 1'b1, 8'h00, 0);
    n_vec++; if (rsp_data !== 8'hCE) begin n_err++; $display("FAIL mem_readback: got %h want ce", rsp_data); end
    @(negedge clk);
    run_frame(0, 7'h13, 1'b1, 8'hFF, 0);
    n_vec++; if ((^rsp_data) === 1'bx) begin n_err++; $display("FAIL mem_unwritten_x: got %h want no X", rsp_data); end
    n_vec++; if (rsp_data !== exp_mem[0][7'h13]) begin n_err++; $display("FAIL mem_unwritten: got %h want %h", rsp_data, exp_mem[0][7'h13]); end
  endtask

  task automatic test_random(input bit s, input int n);
    logic [6:0] a;
    logic       r;
    logic [7:0] w, er;
    for (int i = 0; i < n; i++) begin
      a = 7'($urandom_range(0, 127));
      r = 1'($urandom_range(0, 1));
      w = 8'($urandom_range(0, 255));
      if (i % 3 == 2) a = 7'h7E;
      er = r ? exp_mem[s][a] : 8'h00;
      @(negedge clk);
      run_frame(s, a, r, w, 0);
      if (!r) exp_mem[s][a] = w;
      n_vec++; if (obs_bits !== exp_frame(a, r, w)) begin n_err++; $display("FAIL rand_mosi[%0d]: got %h want %h", i, obs_bits, exp_frame(a, r, w)); end
      n_vec++; if (rsp_data !== er || rsp_cnt != 1) begin n_err++; $display("FAIL rand_rsp[%0d]: got %h x%0d want %h x1", i, rsp_data, rsp_cnt, er); end
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] a;
    logic [7:0] w;
    a = 7'($urandom_range(0, 127));
    w = 8'($urandom_range(0, 255));
    nxt_addr = a; nxt_rw = 1'b1; nxt_wdata = ~w;
    @(negedge clk);
    run_frame(0, a, 1'b0, w, 1);
    exp_mem[0][a] = w;
    n_vec++; if (obs_bits !== exp_frame(a, 1'b0, w)) begin n_err++; $display("FAIL b2b_first_mosi: got %h want %h", obs_bits, exp_frame(a, 1'b0, w)); end
    n_vec++; if (ready_t != 141) begin n_err++; $display("FAIL b2b_ready_time: got %0d want 141", ready_t); end
    n_vec++; if (gap_cnt != 8) begin n_err++; $display("FAIL b2b_cs_gap: got %0d want 8", gap_cnt); end
    run_frame(0, nxt_addr, nxt_rw, nxt_wdata, 0);
    n_vec++; if (wait_cyc != 0) begin n_err++; $display("FAIL b2b_accept_delay: got %0d want 0", wait_cyc); end
    n_vec++; if (obs_bits !== exp_frame(a, 1'b1, 8'h00)) begin n_err++; $display("FAIL b2b_second_mosi: got %h want %h", obs_bits, exp_frame(a, 1'b1, 8'h00)); end
    n_vec++; if (rsp_data !== exp_mem[0][a]) begin n_err++; $display("FAIL b2b_rdata: got %h want %h", rsp_data, exp_mem[0][a]); end
  endtask

  task automatic test_reset_mid;
    int rises, k;
    logic ps;
    logic [6:0] a;
    logic [7:0] w;
    sel = 0;
    @(negedge clk);
    cmd_addr = 7'($urandom_range(0, 127)); cmd_rw = 1'b0; cmd_wdata = 8'($urandom_range(0, 255));
    cmd_valid4 = 1'b1;
    @(negedge clk);
    cmd_valid4 = 1'b0;
    rises = 0; k = 0; ps = sclk4;
    while (rises < 5 && k < 400) begin
      @(negedge clk); k++;
      if (sclk4 && !ps) rises++;
      ps = sclk4;
    end
    n_vec++; if (rises != 5) begin n_err++; $display("FAIL rstmid_edges: got %0d want 5", rises); end
    #3 reset = 1'b1;
    #1;
    n_vec++; if (cs4 !== 1'b1) begin n_err++; $display("FAIL rstmid_cs: got %b want 1", cs4); end
    n_vec++; if (sclk4 !== 1'b0) begin n_err++; $display("FAIL rstmid_sclk: got %b want 0", sclk4); end
    n_vec++; if (cmd_ready4 !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b want 1", cmd_ready4); end
    n_vec++; if (rsp_valid4 !== 1'b0) begin n_err++; $display("FAIL rstmid_rv: got %b want 0", rsp_valid4); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (rsp_valid4 !== 1'b0) begin n_err++; $display("FAIL rstmid_no_rsp: got %b want 0", rsp_valid4); end
    a = 7'($urandom_range(0, 127));
    w = 8'($urandom_range(0, 255));
    run_frame(0, a, 1'b0, w, 0);
    exp_mem[0][a] = w;
    n_vec++; if (n_rise != 16 || obs_bits !== exp_frame(a, 1'b0, w)) begin n_err++; $display("FAIL rstmid_next_frame: got %0d edges %h want 16 edges %h", n_rise, obs_bits, exp_frame(a, 1'b0, w)); end
    @(negedge clk);
    run_frame(0, a, 1'b1, 8'h00, 0);
    n_vec++; if (rsp_data !== w) begin n_err++; $display("FAIL rstmid_readback: got %h want %h", rsp_data, w); end
  endtask

  task automatic test_clkdiv2;
    logic [6:0] a;
    a = 7'($urandom_range(0, 127));
    @(negedge clk);
    run_frame(1, a, 1'b0, 8'h5A, 0);
    exp_mem[1][a] = 8'h5A;
    n_vec++; if (bad_runs != 0 || n_rise != 16) begin n_err++; $display("FAIL cd2_half_period: got %0d bad, %0d edges want 0, 16", bad_runs, n_rise); end
    n_vec++; if (first_rise_t != 3 || cs_low != 66) begin n_err++; $display("FAIL cd2_timing: got rise %0d cs_low %0d want 3 66", first_rise_t, cs_low); end
    n_vec++; if (rsp_t != 67 || ready_t != 71) begin n_err++; $display("FAIL cd2_end_timing: got rsp %0d rdy %0d want 67 71", rsp_t, ready_t); end
    @(negedge clk);
    run_frame(1, a, 1'b1, 8'h00, 0);
    n_vec++; if (rsp_data !== 8'h5A) begin n_err++; $display("FAIL cd2_readback: got %h want 5a", rsp_data); end
    n_vec++; if (bad_runs != 0) begin n_err++; $display("FAIL cd2_read_half_period: got %0d bad want 0", bad_runs); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_write;
    test_read;
    test_memory;
    test_back_to_back;
    test_random(0, 8);
    test_reset_mid;
    test_clkdiv2;
    test_random(1, 6);
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
